vx_dispatch_gather: RTL and testbench
=====================================

// Module: VX_dispatch_gather
// PURPOSE
//  Consumer (slave) end of the dispatch interface, placed at a vector-capable functional unit's input.
//  Scalar packets (is_vec=0) pass through as single-beat ops.
//  A vector op arrives as consecutive beats (vd_lane_id 0..n-1, final beat vd_is_last=1).
//  Beats are collected into one wide op (header + per-lane rs1/rs2/rs3) and issued once complete.
// PARAMETERS
//  MAX_LANES    4   max beats per vector op; lane storage depth
//  LANE_BITS    `CLOG2(MAX_LANES)   lane index width (>=1)
//  OUT_BUF      1   1: registered output stage; 0: output driven from gather regs (same timing, no skid)
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high
//  dispatch_if   slave  VX_dispatch_if.slave   valid/data/ready, in-order per-FU beats
//  out_valid     out  1    gathered op valid
//  out_hdr       out  hdr_t   uuid, wis, tmask, PC, op_type, op_args, wb, rd, vd, tid, is_vec
//  out_rs1/2/3   out  [MAX_LANES][NUM_THREADS][XLEN]   per-lane operands; lane 0 used for scalar
//  out_lane_mask out  MAX_LANES   lanes received
//  out_num_lanes out  LANE_BITS+1   count of distinct lanes received (1 for scalar)
//  out_ready     in   1    downstream accept
//  err_pulse     out  1    1-cycle pulse on protocol error (see below)
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_lane_mask=0, out_num_lanes=0, err_pulse=0, dispatch_if.ready=1. Header/data regs don't care.
//  Handshake: a beat is taken when valid&&ready. out op retires when out_valid&&out_ready. out_* stable while out_valid&&!out_ready.
//  dispatch_if.ready = (state!=ISSUE) || out_ready  -> back-to-back scalar ops at 1/cycle.
//  FSM states: IDLE, GATHER, ISSUE.
//   IDLE/ISSUE-with-retire + beat, is_vec=0: latch header, lane0 data; mask=1, num=1 -> ISSUE.
//   IDLE + beat, is_vec=1: latch header; write lane[vd_lane_id]; set mask bit.
//     Next state: ISSUE if vd_is_last, else GATHER.
//   GATHER + beat: write lane[vd_lane_id], set mask bit; vd_is_last -> ISSUE. Header not reloaded.
//   ISSUE + out_ready, no beat -> IDLE. ISSUE + !out_ready -> hold, ready=0.
//  num_lanes = popcount(mask); duplicate lane_id overwrites data, count unchanged.
//  Latency: last beat accepted in cycle N -> out_valid in cycle N+1.
//  Errors (err_pulse=1 in cycle after offending beat):
//   (a) vd_lane_id >= MAX_LANES: beat consumed, data dropped, FSM advances normally.
//   (b) GATHER beat with uuid or wis != latched header, or is_vec=0: the partial op is discarded.
//       The offending beat is then processed as an IDLE arrival.
//  Single-beat vector op (lane 0, vd_is_last=1 on first beat) behaves like a scalar op: num=1, is_vec=1.
//  Reset mid-gather/ISSUE: partial/pending op lost, no out_valid next cycle.
//  tmask, wb, rd, vd, tid come from the first beat only.
// STRUCTURE
//  VX_gpu_pkg: hdr_t typedef; gather_state_e {IDLE,GATHER,ISSUE}.
//  Sub-module: VX_gather_lane_buf (MAX_LANES x 3 operand regs, write-by-index, mask/popcount).
//  OUT_BUF=1 output uses existing VX_elastic_buffer (SIZE=2) on the packed output.
//  Builds only with EXT_V_ENABLE; otherwise the module is a plain scalar pass-through stage.
// TESTING
//  1 Scalar op, out_ready=1: out_valid next cycle, num_lanes=1, mask=0001, rs1 lane0 matches.
//  2 3 scalar ops back-to-back, out_ready=1: 3 consecutive out_valid cycles, ready never drops.
//  3 Vector lanes 0,1,2,3, last on lane 3, uuid=5: one out op, mask=1111, num=4, per-lane data correct, 1-cycle latency.
//  4 Vector op complete with out_ready=0 for 5 cycles: outputs stable, dispatch ready=0; release -> retires, next beat accepted same cycle.
//  5 Lane 1 sent twice (A then B), then last on lane 2: num=2, lane1 data=B.
//    Separate stimulus with lane_id=7 (MAX_LANES=4): err_pulse, beat dropped.
//  6 Gather lanes 0,1 of wis=2, then beat with wis=3: err_pulse, partial op discarded.
//    New op starts from the wis=3 beat. Assert reset during GATHER: no out_valid follows.

Source files
------------

// File: rtl/vx_dispatch_gather_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vx_dispatch_gather_pkg
// Purpose : Shared types and sizes for the dispatch gather stage
//           (op header layout, gather FSM state encoding).
// Revision: 1.0 - initial release
// ============================================================================
package vx_dispatch_gather_pkg;

  localparam int NUM_THREADS = 2;
  localparam int XLEN        = 16;
  localparam int NW_BITS     = 2;
  localparam int NT_BITS     = 1;
  localparam int UUID_BITS   = 8;
  // One operand slot holds every thread's value for one lane.
  localparam int OPW         = NUM_THREADS * XLEN;

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wis;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [3:0]             op_type;
    logic [7:0]             op_args;
    logic                   wb;
    logic [4:0]             rd;
    logic [4:0]             vd;
    logic [NT_BITS-1:0]     tid;
    logic                   is_vec;
  } hdr_t;

  localparam int HDR_W = $bits(hdr_t);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_ISSUE  = 2'd2
  } gather_state_e;

endpackage : vx_dispatch_gather_pkg
`default_nettype wire

// File: rtl/vx_dispatch_gather_lane_buf.sv
`default_nettype none
// ============================================================================
// Module  : vx_dispatch_gather_lane_buf
// Purpose : Per-lane rs1/rs2/rs3 storage written by lane index, with a
//           received-lane mask and its population count.
// Revision: 1.0 - initial release
// ============================================================================
module vx_dispatch_gather_lane_buf
  import vx_dispatch_gather_pkg::*;
#(
  parameter int MAX_LANES = 4,
  parameter int LANE_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [LANE_BITS-1:0]     wr_idx,
  input  logic [OPW-1:0]           wr_rs1,
  input  logic [OPW-1:0]           wr_rs2,
  input  logic [OPW-1:0]           wr_rs3,
  output logic [MAX_LANES*OPW-1:0] rs1,
  output logic [MAX_LANES*OPW-1:0] rs2,
  output logic [MAX_LANES*OPW-1:0] rs3,
  output logic [MAX_LANES-1:0]     mask,
  output logic [LANE_BITS:0]       num
);

  logic [MAX_LANES-1:0] wr_onehot;

  assign wr_onehot = wr_en ? (MAX_LANES'(1) << wr_idx) : '0;

  // Mask restarts on clear; a new op's first lane is merged in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
    end else if (clear || wr_en) begin
      mask <= (clear ? '0 : mask) | wr_onehot;
    end
  end

  for (genvar i = 0; i < MAX_LANES; i++) begin : g_lane
    localparam logic [LANE_BITS-1:0] LANE_IDX = LANE_BITS'(i);
    logic [OPW-1:0] rs1_q, rs2_q, rs3_q;

    // Operand data is not reset; a duplicate lane index simply overwrites.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == LANE_IDX)) begin
        rs1_q <= wr_rs1;
        rs2_q <= wr_rs2;
        rs3_q <= wr_rs3;
      end
    end

    assign rs1[i*OPW +: OPW] = rs1_q;
    assign rs2[i*OPW +: OPW] = rs2_q;
    assign rs3[i*OPW +: OPW] = rs3_q;
  end

  // Distinct lanes received = popcount of the mask.
  always_comb begin
    num = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      num = num + {{LANE_BITS{1'b0}}, mask[i]};
    end
  end

endmodule : vx_dispatch_gather_lane_buf
`default_nettype wire

// File: rtl/vx_dispatch_gather.sv
`default_nettype none
// ============================================================================
// Module  : vx_dispatch_gather
// Purpose : Dispatch consumer for a vector-capable FU. Scalar packets pass
//           as single-beat ops; vector beats are gathered per lane into one
//           wide op that issues the cycle after its last beat.
// Revision: 1.0 - initial release
// ============================================================================
module vx_dispatch_gather
  import vx_dispatch_gather_pkg::*;
#(
  parameter int MAX_LANES = 4,
  parameter int LANE_BITS = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  // dispatch side; lane id has one spare bit so out-of-range ids are visible
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [HDR_W-1:0]         dispatch_hdr,
  input  logic [LANE_BITS:0]       dispatch_vd_lane_id,
  input  logic                     dispatch_vd_is_last,
  input  logic [OPW-1:0]           dispatch_rs1,
  input  logic [OPW-1:0]           dispatch_rs2,
  input  logic [OPW-1:0]           dispatch_rs3,
  // gathered op
  output logic                     out_valid,
  output logic [HDR_W-1:0]         out_hdr,
  output logic [MAX_LANES*OPW-1:0] out_rs1,
  output logic [MAX_LANES*OPW-1:0] out_rs2,
  output logic [MAX_LANES*OPW-1:0] out_rs3,
  output logic [MAX_LANES-1:0]     out_lane_mask,
  output logic [LANE_BITS:0]       out_num_lanes,
  input  logic                     out_ready,
  output logic                     err_pulse
);

  gather_state_e        state_q, state_d;
  hdr_t                 in_hdr, hdr_q;
  logic                 fire, lane_ok, mismatch, start_op;
  logic                 buf_clear, buf_wr, hdr_load, err_d;
  logic [LANE_BITS-1:0] buf_idx;

  assign in_hdr         = hdr_t'(dispatch_hdr);
  // Only a pending, unaccepted op blocks the input; a retiring op does not.
  assign dispatch_ready = (state_q != S_ISSUE) || out_ready;
  assign fire           = dispatch_valid && dispatch_ready;
  assign lane_ok        = dispatch_vd_lane_id < (LANE_BITS+1)'(MAX_LANES);
  assign mismatch       = (in_hdr.uuid != hdr_q.uuid) || (in_hdr.wis != hdr_q.wis)
                          || !in_hdr.is_vec;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls. A foreign beat during GATHER drops
  // the partial op and is then handled exactly like an IDLE arrival.
  always_comb begin
    state_d   = state_q;
    start_op  = 1'b0;
    buf_clear = 1'b0;
    buf_wr    = 1'b0;
    buf_idx   = '0;
    hdr_load  = 1'b0;
    err_d     = 1'b0;
    if (fire) begin
      start_op = (state_q != S_GATHER) || mismatch;
      if ((state_q == S_GATHER) && mismatch) begin
        err_d = 1'b1;
      end
      if (start_op) begin
        buf_clear = 1'b1;
        hdr_load  = 1'b1;
      end
      if (!in_hdr.is_vec) begin
        buf_wr  = 1'b1;
        state_d = S_ISSUE;
      end else begin
        if (lane_ok) begin
          buf_wr  = 1'b1;
          buf_idx = dispatch_vd_lane_id[LANE_BITS-1:0];
        end else begin
          err_d = 1'b1;
        end
        state_d = dispatch_vd_is_last ? S_ISSUE : S_GATHER;
      end
    end else if ((state_q == S_ISSUE) && out_ready) begin
      state_d = S_IDLE;
    end
  end

  // Header captured from the first beat of an op only.
  always_ff @(posedge clk) begin
    if (hdr_load) begin
      hdr_q <= in_hdr;
    end
  end

  // Protocol error flag, one cycle after the offending beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_d;
    end
  end

  vx_dispatch_gather_lane_buf #(
    .MAX_LANES (MAX_LANES),
    .LANE_BITS (LANE_BITS)
  ) u_lane_buf (
    .clk    (clk),
    .reset  (reset),
    .clear  (buf_clear),
    .wr_en  (buf_wr),
    .wr_idx (buf_idx),
    .wr_rs1 (dispatch_rs1),
    .wr_rs2 (dispatch_rs2),
    .wr_rs3 (dispatch_rs3),
    .rs1    (out_rs1),
    .rs2    (out_rs2),
    .rs3    (out_rs3),
    .mask   (out_lane_mask),
    .num    (out_num_lanes)
  );

  assign out_valid = (state_q == S_ISSUE);
  assign out_hdr   = hdr_q;

endmodule : vx_dispatch_gather
`default_nettype wire

// File: tb/tb_vx_dispatch_gather.sv
`default_nettype none
// ============================================================================
// Module  : tb_vx_dispatch_gather
// Purpose : Scoreboard bench for vx_dispatch_gather: a behavioural model
//           predicts each gathered op as beats are accepted; a monitor
//           compares ops as they retire.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vx_dispatch_gather;
  import vx_dispatch_gather_pkg::*;

  localparam int ML = 4;
  localparam int LB = 2;

  typedef struct {
    hdr_t              hdr;
    logic [ML-1:0]     mask;
    logic [ML*OPW-1:0] rs1, rs2, rs3;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              dispatch_valid, dispatch_ready;
  hdr_t              dispatch_hdr;
  logic [LB:0]       dispatch_vd_lane_id;
  logic              dispatch_vd_is_last;
  logic [OPW-1:0]    dispatch_rs1, dispatch_rs2, dispatch_rs3;
  logic              out_valid, out_ready, err_pulse;
  logic [HDR_W-1:0]  out_hdr;
  logic [ML*OPW-1:0] out_rs1, out_rs2, out_rs3;
  logic [ML-1:0]     out_lane_mask;
  logic [LB:0]       out_num_lanes;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int retired  = 0;

  exp_t exp_q[$];

  // reference model state
  bit                m_gath;
  exp_t              m_op;

  vx_dispatch_gather #(.MAX_LANES(ML)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .dispatch_hdr        (dispatch_hdr),
    .dispatch_vd_lane_id (dispatch_vd_lane_id),
    .dispatch_vd_is_last (dispatch_vd_is_last),
    .dispatch_rs1        (dispatch_rs1),
    .dispatch_rs2        (dispatch_rs2),
    .dispatch_rs3        (dispatch_rs3),
    .out_valid           (out_valid),
    .out_hdr             (out_hdr),
    .out_rs1             (out_rs1),
    .out_rs2             (out_rs2),
    .out_rs3             (out_rs3),
    .out_lane_mask       (out_lane_mask),
    .out_num_lanes       (out_num_lanes),
    .out_ready           (out_ready),
    .err_pulse           (err_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic hdr_t mk_hdr(input int uuid, input int wis, input bit is_vec);
    hdr_t h;
    h         = hdr_t'({$urandom, $urandom, $urandom});
    h.uuid    = UUID_BITS'(uuid);
    h.wis     = NW_BITS'(wis);
    h.is_vec  = is_vec;
    return h;
  endfunction

  // Behavioural prediction of one accepted beat.
  task automatic model_beat(input hdr_t h, input int lid, input bit last,
                            input logic [OPW-1:0] a, b, c);
    int idx;
    if (m_gath && (h.uuid != m_op.hdr.uuid || h.wis != m_op.hdr.wis || !h.is_vec)) begin
      err_exp++;
      m_gath = 1'b0;
    end
    if (!m_gath) begin
      m_op.hdr  = h;
      m_op.mask = '0;
    end
    idx = -1;
    if (!h.is_vec) idx = 0;
    else if (lid >= ML) err_exp++;
    else idx = lid;
    if (idx >= 0) begin
      m_op.mask[idx] = 1'b1;
      m_op.rs1[idx*OPW +: OPW] = a;
      m_op.rs2[idx*OPW +: OPW] = b;
      m_op.rs3[idx*OPW +: OPW] = c;
    end
    if (!h.is_vec || last) begin
      exp_q.push_back(m_op);
      m_gath = 1'b0;
    end else begin
      m_gath = 1'b1;
    end
  endtask

  // Drive one beat until accepted; returns the number of cycles it took.
  task automatic send_beat(input hdr_t h, input int lid, input bit last, output int ncyc);
    logic [OPW-1:0] a, b, c;
    bit acc;
    a = OPW'($urandom); b = OPW'($urandom); c = OPW'($urandom);
    dispatch_hdr        = h;
    dispatch_vd_lane_id = (LB+1)'(lid);
    dispatch_vd_is_last = last;
    dispatch_rs1        = a;
    dispatch_rs2        = b;
    dispatch_rs3        = c;
    dispatch_valid      = 1'b1;
    acc  = 1'b0;
    ncyc = 0;
    while (!acc && ncyc < 50) begin
      @(negedge clk);
      acc = dispatch_ready;
      @(posedge clk);
      #1;
      ncyc++;
    end
    dispatch_valid = 1'b0;
    chk("beat_accepted", acc, 1'b1);
    if (acc) model_beat(h, lid, last, a, b, c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_gath = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Retirement monitor: compares each retired op with the scoreboard head
  // and checks that a stalled op holds its outputs.
  logic              hold_prev = 1'b0;
  logic [HDR_W-1:0]  prev_hdr;
  logic [ML-1:0]     prev_mask;
  logic [ML*OPW-1:0] prev_rs1;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (err_pulse) err_seen++;
      if (hold_prev) begin
        chk("hold_hdr", out_hdr, prev_hdr);
        chk("hold_mask", out_lane_mask, prev_mask);
        chk("hold_rs1", out_rs1, prev_rs1);
      end
      if (out_valid && out_ready) begin
        retired++;
        chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          logic [ML*OPW-1:0] bm;
          e = exp_q.pop_front();
          for (int i = 0; i < ML; i++) bm[i*OPW +: OPW] = {OPW{e.mask[i]}};
          chk("out_hdr", out_hdr, e.hdr);
          chk("out_lane_mask", out_lane_mask, e.mask);
          chk("out_num_lanes", out_num_lanes, $countones(e.mask));
          chk("out_rs1", out_rs1 & bm, e.rs1 & bm);
          chk("out_rs2", out_rs2 & bm, e.rs2 & bm);
          chk("out_rs3", out_rs3 & bm, e.rs3 & bm);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_hdr  = out_hdr;
      prev_mask = out_lane_mask;
      prev_rs1  = out_rs1;
    end
  end

  initial begin
    int n, t0, r0;
    dispatch_valid = 1'b0;
    dispatch_hdr = '0; dispatch_vd_lane_id = '0; dispatch_vd_is_last = 1'b0;
    dispatch_rs1 = '0; dispatch_rs2 = '0; dispatch_rs3 = '0;
    out_ready = 1'b1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_lane_mask", out_lane_mask, '0);
    chk("rst_num_lanes", out_num_lanes, '0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_ready", dispatch_ready, 1'b1);
    @(posedge clk); #1;

    // 1: single scalar op, one-cycle latency
    send_beat(mk_hdr(1, 0, 1'b0), 0, 1'b1, n);
    @(negedge clk);
    chk("t1_latency_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // 2: three scalar ops back to back at full rate
    t0 = cyc; r0 = retired;
    send_beat(mk_hdr(2, 1, 1'b0), 0, 1'b1, n);
    send_beat(mk_hdr(3, 2, 1'b0), 2, 1'b0, n);
    send_beat(mk_hdr(4, 3, 1'b0), 0, 1'b1, n);
    chk("t2_cycles", cyc - t0, 3);
    drain();
    chk("t2_retired", retired - r0, 3);

    // 3: full vector op, lanes 0..3
    for (int l = 0; l < ML; l++) send_beat(mk_hdr(5, 1, 1'b1), l, l == ML - 1, n);
    @(negedge clk);
    chk("t3_latency_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // 4: completed op held by backpressure, then released with a new beat
    out_ready = 1'b0;
    send_beat(mk_hdr(6, 2, 1'b1), 0, 1'b0, n);
    send_beat(mk_hdr(6, 2, 1'b1), 1, 1'b1, n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_ready_low", dispatch_ready, 1'b0);
      chk("t4_valid_held", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(mk_hdr(7, 0, 1'b0), 0, 1'b1, n);
    chk("t4_same_cycle_accept", n, 1);
    drain();

    // 5: duplicate lane overwrite, then out-of-range lane id
    send_beat(mk_hdr(8, 1, 1'b1), 1, 1'b0, n);
    send_beat(mk_hdr(8, 1, 1'b1), 1, 1'b0, n);
    send_beat(mk_hdr(8, 1, 1'b1), 2, 1'b1, n);
    drain();
    send_beat(mk_hdr(9, 3, 1'b1), 0, 1'b0, n);
    send_beat(mk_hdr(9, 3, 1'b1), 7, 1'b0, n);
    @(negedge clk);
    chk("t5_err_lane7", err_pulse, 1'b1);
    @(posedge clk); #1;
    send_beat(mk_hdr(9, 3, 1'b1), 1, 1'b1, n);
    drain();

    // 6: foreign warp mid-gather restarts the op from the offending beat
    send_beat(mk_hdr(10, 2, 1'b1), 0, 1'b0, n);
    send_beat(mk_hdr(10, 2, 1'b1), 1, 1'b0, n);
    send_beat(mk_hdr(10, 3, 1'b1), 0, 1'b0, n);
    @(negedge clk);
    chk("t6_err_wis", err_pulse, 1'b1);
    chk("t6_no_partial_issue", out_valid, 1'b0);
    @(posedge clk); #1;
    send_beat(mk_hdr(10, 3, 1'b1), 1, 1'b1, n);
    drain();

    // 6b: reset during GATHER loses the partial op
    send_beat(mk_hdr(11, 0, 1'b1), 0, 1'b0, n);
    exp_q.delete();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_rst_no_valid", out_valid, 1'b0);
      chk("t6_rst_mask", out_lane_mask, '0);
      @(posedge clk); #1;
    end
    // a fresh op after reset still works
    send_beat(mk_hdr(12, 1, 1'b1), 0, 1'b1, n);
    drain();

    @(posedge clk); #1;
    chk("err_pulse_count", err_seen, err_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vx_dispatch_gather
`default_nettype wire
